fetch_unit: RTL and testbench

Instruction-fetch stage of the MIPS R2000 five-stage pipeline, sitting directly upstream of the decode stage. Holds the program counter and a word-addressed instruction memory, and registers the fetched instruction plus its PC+4 into the IF/ID pipeline register that decode consumes. Supports stall (hold), redirect (branch/jump from decode, with a flush of the wrong-path slot), a start-gated boot state for memory preload, and a halt on misaligned redirect targets.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_imem.sv | 24 ++
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 135 +++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: NOP encoding, fetch FSM states and the IF/ID payload.
package mips_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{inst: NOP, pc_plus4: 32'd0, valid: 1'b0};

endpackage

// File: rtl/fetch_unit_if.sv
// Control, preload and IF/ID output bundle of the fetch stage.
interface fetch_unit_if #(
    parameter int unsigned IMEM_DEPTH = 256
);
    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    logic          start;
    logic          stall;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;

    logic [31:0]   pc;
    logic [31:0]   inst_out;
    logic [31:0]   pc_plus4_out;
    logic          valid_out;
    logic          fault;

    modport master (
        output start, stall, redirect, redirect_pc, imem_we, imem_waddr, imem_wdata,
        input  pc, inst_out, pc_plus4_out, valid_out, fault
    );

    modport slave (
        input  start, stall, redirect, redirect_pc, imem_we, imem_waddr, imem_wdata,
        output pc, inst_out, pc_plus4_out, valid_out, fault
    );

endinterface

// File: rtl/fetch_imem.sv
// Word-addressed instruction memory: asynchronous read, synchronous write, never cleared.
module fetch_imem #(
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [31:0]              i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [31:0]              o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Same-cycle write is not forwarded; the new word is visible after the edge.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_unit.sv
// MIPS R2000 instruction-fetch stage: PC, boot/run/halt control and the IF/ID register.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    fetch_unit_if.slave bus
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    ifid_t        r_ifid, w_ifid_nxt;
    logic         r_fault, w_fault_nxt;

    logic [31:0]  w_rdata;
    logic [31:0]  w_pc_plus4;
    logic         w_misaligned;

    fetch_imem #(
        .DEPTH (IMEM_DEPTH)
    ) u_imem (
        .clk     (clk),
        .i_we    (bus.imem_we),
        .i_waddr (bus.imem_waddr),
        .i_wdata (bus.imem_wdata),
        .i_raddr (r_pc[AW+1:2]),
        .o_rdata (w_rdata)
    );

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_misaligned = (bus.redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
            r_ifid  <= IFID_BUBBLE;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ifid  <= w_ifid_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    // Priority in RUN: redirect, then stall, then sequential fetch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ifid_nxt  = r_ifid;
        w_fault_nxt = r_fault;

        case (r_state)
            BOOT: begin
                if (bus.start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.redirect) begin
                    w_ifid_nxt = IFID_BUBBLE;
                    if (w_misaligned) begin
                        w_state_nxt = HALT;
                        w_fault_nxt = 1'b1;
                    end else begin
                        w_pc_nxt = bus.redirect_pc;
                    end
                end else if (!bus.stall) begin
                    w_pc_nxt            = w_pc_plus4;
                    w_ifid_nxt.inst     = w_rdata;
                    w_ifid_nxt.pc_plus4 = w_pc_plus4;
                    w_ifid_nxt.valid    = 1'b1;
                end
            end
            HALT: begin
                w_state_nxt = HALT;
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    assign bus.pc           = r_pc;
    assign bus.inst_out     = r_ifid.inst;
    assign bus.pc_plus4_out = r_ifid.pc_plus4;
    assign bus.valid_out    = r_ifid.valid;
    assign bus.fault        = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit: driver queues expected IF state, monitor checks each edge.
module tb_fetch_unit;

    localparam int unsigned IMEM_DEPTH = 256;

    typedef struct {
        string       nm;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] p4;
        logic        v;
        logic        f;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_unit_if #(.IMEM_DEPTH(IMEM_DEPTH)) bus ();

    fetch_unit #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .RESET_PC   (32'h0000_0000)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic void cmp(input string nm, input string fld,
                                input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endfunction

    // Monitor: one expected IF state per edge, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp(e.nm, "pc",       bus.pc,                   e.pc);
            cmp(e.nm, "inst_out", bus.inst_out,             e.inst);
            cmp(e.nm, "pc_plus4", bus.pc_plus4_out,         e.p4);
            cmp(e.nm, "valid",    32'(bus.valid_out),       32'(e.v));
            cmp(e.nm, "fault",    32'(bus.fault),           32'(e.f));
        end
    end

    task automatic step(input string nm, input logic r, input logic st, input logic stl,
                        input logic rd, input logic [31:0] rpc,
                        input logic we, input logic [7:0] wa, input logic [31:0] wd,
                        input logic [31:0] epc, input logic [31:0] einst,
                        input logic [31:0] ep4, input logic ev, input logic ef);
        exp_t e;
        @(negedge clk);
        rst             = r;
        bus.start       = st;
        bus.stall       = stl;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.imem_we     = we;
        bus.imem_waddr  = wa;
        bus.imem_wdata  = wd;
        e.nm = nm; e.pc = epc; e.inst = einst; e.p4 = ep4; e.v = ev; e.f = ef;
        exp_q.push_back(e);
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.imem_we     = 1'b0;
        bus.imem_waddr  = 8'd0;
        bus.imem_wdata  = 32'd0;

        //    name          rst st stl rd rpc            we wa    wd             pc             inst           p4             v f
        step("reset",       1, 0, 0, 0, 32'h0,         0, 8'd0, 32'h0,         32'h0,         32'h0,         32'h0,         0, 0);
        step("load0",       0, 0, 0, 0, 32'h0,         1, 8'd0, 32'h11,        32'h0,         32'h0,         32'h0,         0, 0);
        step("load1",       0, 0, 0, 0, 32'h0,         1, 8'd1, 32'h22,        32'h0,         32'h0,         32'h0,         0, 0);
        step("load2",       0, 0, 0, 0, 32'h0,         1, 8'd2, 32'h33,        32'h0,         32'h0,         32'h0,         0, 0);
        step("load3",       0, 0, 0, 0, 32'h0,         1, 8'd3, 32'h44,        32'h0,         32'h0,         32'h0,         0, 0);
        step("start",       0, 1, 0, 0, 32'h0,         0, 8'd0, 32'h0,         32'h0,         32'h0,         32'h0,         0, 0);
        step("fetch11",     0, 0, 0, 0, 32'h0,         0, 8'd0, 32'h0,         32'h4,         32'h11,        32'h4,         1, 0);
        step("fetch22",     0, 0, 0, 0, 32'h0,         0, 8'd0, 32'h0,         32'h8,         32'h22,        32'h8,         1, 0);
        step("stall1",      0, 0, 1, 0, 32'h0,         0, 8'd0, 32'h0,         32'h8,         32'h22,        32'h8,         1, 0);
        step("stall2",      0, 0, 1, 0, 32'h0,         0, 8'd0, 32'h0,         32'h8,         32'h22,        32'h8,         1, 0);
        step("stall3",      0, 0, 1, 0, 32'h0,         0, 8'd0, 32'h0,         32'h8,         32'h22,        32'h8,         1, 0);
        step("fetch33",     0, 0, 0, 0, 32'h0,         0, 8'd0, 32'h0,         32'hC,         32'h33,        32'hC,         1, 0);
        step("fetch44",     0, 0, 0, 0, 32'h0,         0, 8'd0, 32'h0,         32'h10,        32'h44,        32'h10,        1, 0);
        step("redir_stall", 0, 0, 1, 1, 32'hC,         0, 8'd0, 32'h0,         32'hC,         32'h0,         32'h0,         0, 0);
        step("redir_tgt",   0, 0, 0, 0, 32'h0,         1, 8'd255, 32'hFF,      32'h10,        32'h44,        32'h10,        1, 0);
        step("redir_3fc",   0, 0, 0, 1, 32'h3FC,       0, 8'd0, 32'h0,         32'h3FC,       32'h0,         32'h0,         0, 0);
        step("fetch255",    0, 0, 0, 0, 32'h0,         0, 8'd0, 32'h0,         32'h400,       32'hFF,        32'h400,       1, 0);
        step("wrap_mem",    0, 0, 0, 0, 32'h0,         0, 8'd0, 32'h0,         32'h404,       32'h11,        32'h404,       1, 0);
        step("wr_collide",  0, 0, 0, 0, 32'h0,         1, 8'd1, 32'hDEADBEEF,  32'h408,       32'h22,        32'h408,       1, 0);
        step("redir_4",     0, 0, 0, 1, 32'h4,         0, 8'd0, 32'h0,         32'h4,         32'h0,         32'h0,         0, 0);
        step("refetch_new", 0, 0, 0, 0, 32'h0,         0, 8'd0, 32'h0,         32'h8,         32'hDEADBEEF,  32'h8,         1, 0);
        step("redir_top",   0, 0, 0, 1, 32'hFFFFFFFC,  0, 8'd0, 32'h0,         32'hFFFFFFFC,  32'h0,         32'h0,         0, 0);
        step("pc_wrap32",   0, 0, 0, 0, 32'h0,         0, 8'd0, 32'h0,         32'h0,         32'hFF,        32'h0,         1, 0);
        step("after_wrap",  0, 0, 0, 0, 32'h0,         0, 8'd0, 32'h0,         32'h4,         32'h11,        32'h4,         1, 0);
        step("misalign",    0, 0, 0, 1, 32'h6,         0, 8'd0, 32'h0,         32'h4,         32'h0,         32'h0,         0, 1);
        step("halt_ignore", 0, 1, 0, 1, 32'h10,        0, 8'd0, 32'h0,         32'h4,         32'h0,         32'h0,         0, 1);
        step("halt_hold",   0, 0, 1, 0, 32'h0,         0, 8'd0, 32'h0,         32'h4,         32'h0,         32'h0,         0, 1);
        step("halt_reset",  1, 1, 0, 1, 32'h10,        0, 8'd0, 32'h0,         32'h0,         32'h0,         32'h0,         0, 0);
        step("boot_hold",   0, 0, 0, 0, 32'h0,         0, 8'd0, 32'h0,         32'h0,         32'h0,         32'h0,         0, 0);
        step("restart",     0, 1, 0, 0, 32'h0,         0, 8'd0, 32'h0,         32'h0,         32'h0,         32'h0,         0, 0);
        step("refetch11",   0, 0, 0, 0, 32'h0,         0, 8'd0, 32'h0,         32'h4,         32'h11,        32'h4,         1, 0);
        step("rst_stall",   1, 0, 1, 0, 32'h0,         0, 8'd0, 32'h0,         32'h0,         32'h0,         32'h0,         0, 0);
        step("boot_again",  0, 0, 0, 0, 32'h0,         0, 8'd0, 32'h0,         32'h0,         32'h0,         32'h0,         0, 0);

        // Drain: the monitor must consume every queued expectation within a few edges.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
